// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results straight to the register file and
// parks loads in WAIT_LOAD until the memory read response (or a timeout).
module wb_stage #(
    parameter int D_BITS       = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exec_valid_i,
    output logic              exec_ready_o,
    input  logic              exec_is_load_i,
    input  logic [2:0]        exec_dest_i,
    input  logic [D_BITS-1:0] exec_result_i,
    input  logic              mem_rvalid_i,
    input  logic [D_BITS-1:0] mem_rdata_i,
    output logic              wen_o,
    output logic [2:0]        dest_o,
    output logic [D_BITS-1:0] result_o,
    output logic              pend_valid_o,
    output logic [2:0]        pend_dest_o,
    input  logic              err_clr_i,
    output logic              err_o,
    output logic              state_o
);

    // Handshake: an instruction is taken on a rising clk_i edge where
    // exec_valid_i & exec_ready_o; EXECUTE holds exec_* stable until then.

    localparam int CNT_RAW = $clog2(LOAD_TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 5) ? 5 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wen_d;
    logic [2:0]          dest_d;
    logic [D_BITS-1:0]   result_d;
    logic                pend_valid_d;
    logic [2:0]          pend_dest_d;
    logic                err_d;
    logic                err_set;

    assign exec_ready_o = (state_q == IDLE);
    assign state_o      = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wen_d        = 1'b0;
        dest_d       = dest_o;
        result_d     = result_o;
        pend_valid_d = pend_valid_o;
        pend_dest_d  = pend_dest_o;
        err_set      = 1'b0;

        case (state_q)
            IDLE: begin
                // A read response with nothing outstanding is a protocol error.
                if (mem_rvalid_i) begin
                    err_set = 1'b1;
                end
                if (exec_valid_i) begin
                    if (exec_is_load_i) begin
                        state_d      = WAIT_LOAD;
                        cnt_d        = '0;
                        pend_valid_d = 1'b1;
                        pend_dest_d  = exec_dest_i;
                    end else begin
                        wen_d    = 1'b1;
                        dest_d   = exec_dest_i;
                        result_d = exec_result_i;
                    end
                end
            end
            WAIT_LOAD: begin
                // A response arriving in the expiry cycle still retires normally.
                if (mem_rvalid_i) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    wen_d        = 1'b1;
                    dest_d       = pend_dest_o;
                    result_d     = mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    err_set      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wen_o        <= 1'b0;
            dest_o       <= '0;
            result_o     <= '0;
            pend_valid_o <= 1'b0;
            pend_dest_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wen_o        <= wen_d;
            dest_o       <= dest_d;
            result_o     <= result_d;
            pend_valid_o <= pend_valid_d;
            pend_dest_o  <= pend_dest_d;
            err_o        <= err_d;
        end
    end

endmodule
